move_seq_ctrl: RTL

- Sequences one straight-line move of the robot by driving the PID block's inputs: moving, err_vld, error and frwrd.
- Accepts a command (desired heading plus square count) and turns in place until the heading settles.
- Then ramps frwrd up, counts cntrIR line crossings, ramps frwrd down and reports completion.
- Sits between the command processor and the PID/motor datapath.

---
 rtl/move_seq_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/move_seq_ctrl.sv
// rtl/move_seq_ctrl.sv - straight-line move sequencer feeding the PID block (optional macro: LINE_TIMEOUT_EN)
module move_seq_ctrl #(
  parameter bit          FAST_SIM  = 1'b1,
  parameter logic [9:0]  FRWRD_MAX = 10'h2A0,
  parameter logic [11:0] ERR_THR   = 12'h030,
  parameter int          TO_W      = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_vld,
  input  logic [11:0] cmd_hdg,
  input  logic [3:0]  cmd_sqrs,
  output logic        cmd_rdy,
  input  logic [11:0] heading,
  input  logic        heading_rdy,
  input  logic        cntrIR,
  output logic [11:0] error,
  output logic        err_vld,
  output logic [9:0]  frwrd,
  output logic        moving,
  output logic        mv_done,
  output logic        fault
);

  localparam logic [9:0]  FRWRD_INC = FAST_SIM ? 10'h020 : 10'h003;
  localparam logic [10:0] DEC_STEP  = {FRWRD_INC, 1'b0};

  typedef enum logic [2:0] {IDLE, TURN, RAMP, DECEL, DONE} state_t;

  state_t          state, next_state;
  logic [11:0]     desired;
  logic [4:0]      target;
  logic [4:0]      line_cnt;
  logic            cntr_ir_q;
  logic            line_edge;
  logic            capture;
  logic [11:0]     err_mag;
  logic            err_small;
  logic [10:0]     frwrd_sum;
  logic [9:0]      frwrd_up;
  logic [9:0]      frwrd_dn;
  logic            line_done;
  logic            ramp_entry;
  logic            to_expire;
  logic [TO_W-1:0] to_cnt;
  logic            moving_d, mv_done_d, cmd_rdy_d;

  assign capture    = cmd_vld & cmd_rdy;
  assign line_edge  = cntrIR & ~cntr_ir_q;
  assign ramp_entry = (state != RAMP) && (next_state == RAMP);

  // 12'h800 negates to itself and therefore compares as a large magnitude
  assign err_mag   = error[11] ? (~error + 12'd1) : error;
  assign err_small = err_mag < ERR_THR;

  // Speed arithmetic is done one bit wider so the ramp can never wrap past 10 bits
  assign frwrd_sum = {1'b0, frwrd} + {1'b0, FRWRD_INC};
  assign frwrd_up  = (frwrd_sum > {1'b0, FRWRD_MAX}) ? FRWRD_MAX : frwrd_sum[9:0];
  assign frwrd_dn  = ({1'b0, frwrd} > DEC_STEP) ? (frwrd - DEC_STEP[9:0]) : 10'd0;

  // The final edge switches to DECEL at the same clock that bumps the count
  assign line_done = (state == RAMP) && line_edge && ((line_cnt + 5'd1) == target);
  assign to_expire = (state == RAMP) && (&to_cnt);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (capture) next_state = TURN;
      TURN:    if (err_vld && err_small) next_state = (target == 5'd0) ? DONE : RAMP;
      RAMP:    if (line_done || to_expire) next_state = DECEL;
      DECEL:   if (frwrd == 10'd0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with the state
  always_comb begin
    moving_d  = (next_state == TURN) || (next_state == RAMP) || (next_state == DECEL);
    mv_done_d = (next_state == DONE);
    cmd_rdy_d = (next_state == IDLE);
  end

  // Registered FSM outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      moving  <= 1'b0;
      mv_done <= 1'b0;
      cmd_rdy <= 1'b1;
    end else begin
      moving  <= moving_d;
      mv_done <= mv_done_d;
      cmd_rdy <= cmd_rdy_d;
    end
  end

  // Command latch and heading error to the PID
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      desired <= 12'd0;
      target  <= 5'd0;
      error   <= 12'd0;
      err_vld <= 1'b0;
    end else begin
      if (capture) begin
        desired <= cmd_hdg;
        target  <= {cmd_sqrs, 1'b0};
      end
      if (heading_rdy) error <= heading - desired;
      err_vld <= heading_rdy && (state != IDLE);
    end
  end

  // Forward speed: ramps up in RAMP, down in DECEL, held at zero elsewhere
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frwrd <= 10'd0;
    end else begin
      case (state)
        RAMP:    if (heading_rdy) frwrd <= frwrd_up;
        DECEL:   if (heading_rdy) frwrd <= frwrd_dn;
        default: frwrd <= 10'd0;
      endcase
    end
  end

  // Line crossing counter; only edges seen while in RAMP count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_cnt  <= 5'd0;
      cntr_ir_q <= 1'b0;
    end else begin
      cntr_ir_q <= cntrIR;
      if (capture || ramp_entry)           line_cnt <= 5'd0;
      else if (state == RAMP && line_edge) line_cnt <= line_cnt + 5'd1;
    end
  end

`ifdef LINE_TIMEOUT_EN
  logic fault_q;

  // Watchdog on line spacing; a stuck sensor aborts the ramp and raises a sticky fault
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt  <= '0;
      fault_q <= 1'b0;
    end else begin
      if (ramp_entry || line_edge)          to_cnt <= '0;
      else if (state == RAMP && !(&to_cnt)) to_cnt <= to_cnt + 1'b1;
      if (capture)        fault_q <= 1'b0;
      else if (to_expire) fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  assign to_cnt = '0;
  assign fault  = 1'b0;
`endif

endmodule
